debounce_delay_module: RTL and testbench

DEBOUNCE_DELAY_MODULE -- requirements
Module: debounce_delay_module

---
 rtl/debounce_delay_module_pkg.sv | 36 +++
 rtl/debounce_delay_module_settle_timer.sv | 27 ++
 rtl/debounce_delay_module.sv | 146 ++++++++++++++
 tb/tb_debounce_delay_module.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_delay_module_pkg.sv
// Shared types and defaults for the key debounce / long-press block.
// Holds the FSM encoding, counter widths and the edge-pulse decoder.
package debounce_delay_module_pkg;

    localparam int unsigned SettleW = 19;
    localparam int unsigned TickW   = 7;

    localparam logic [SettleW-1:0] T10msDefault     = 19'd499_999;
    localparam logic [TickW-1:0]   LongTicksDefault = 7'd100;

    typedef enum logic [1:0] {
        StIdle        = 2'd0,
        StPressWait   = 2'd1,
        StHeld        = 2'd2,
        StReleaseWait = 2'd3
    } state_e;

    typedef enum logic {
        EdgeRelease = 1'b0,
        EdgePress   = 1'b1
    } last_edge_e;

    typedef struct packed {
        logic press;
        logic rel;
    } edge_ev_t;

    // Both pulses in the same cycle cancel out and count as no event.
    function automatic edge_ev_t decode_edges(input logic h2l, input logic l2h);
        edge_ev_t ev;
        ev.press = h2l & ~l2h;
        ev.rel   = l2h & ~h2l;
        return ev;
    endfunction

endpackage

// File: rtl/debounce_delay_module_settle_timer.sv
// Settle interval counter: clear has priority, counts while enabled and
// wraps to zero after the cycle in which it reaches T10MS.
module debounce_delay_module_settle_timer
    import debounce_delay_module_pkg::*;
#(
    parameter logic [SettleW-1:0] T10MS = T10msDefault
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    logic [SettleW-1:0] r_count;

    assign o_done = (r_count == T10MS);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_done ? '0 : r_count + SettleW'(1);
        end
    end

endmodule

// File: rtl/debounce_delay_module.sv
// Key debouncer driven by upstream edge pulses: confirms press/release after a
// quiet settle interval and flags a long press after LONG_TICKS intervals held.
module debounce_delay_module
    import debounce_delay_module_pkg::*;
#(
    parameter logic [SettleW-1:0] T10MS      = T10msDefault,
    parameter logic [TickW-1:0]   LONG_TICKS = LongTicksDefault
) (
    input  logic CLK,
    input  logic RST,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    output logic Key_Out,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Long_Sig
);

    state_e           r_state;
    last_edge_e       r_last_edge;
    logic [TickW-1:0] r_ticks;
    logic             r_key;
    logic             r_press;
    logic             r_release;
    logic             r_long;

    edge_ev_t w_ev;
    logic     w_press;
    logic     w_release;
    logic     w_done;
    logic     w_clr;
    logic     w_en;

    assign w_ev      = decode_edges(H2L_Sig, L2H_Sig);
    assign w_press   = w_ev.press;
    assign w_release = w_ev.rel;

    // Any accepted edge restarts the interval; HELD only listens for release.
    always_comb begin
        w_clr = 1'b1;
        w_en  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_clr = 1'b1;
            end
            StPressWait, StReleaseWait: begin
                w_clr = w_press | w_release;
                w_en  = 1'b1;
            end
            StHeld: begin
                w_clr = w_release;
                w_en  = 1'b1;
            end
            default: begin
                w_clr = 1'b1;
            end
        endcase
    end

    debounce_delay_module_settle_timer #(
        .T10MS (T10MS)
    ) settle_timer (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_done (w_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StIdle;
            r_last_edge <= EdgeRelease;
            r_ticks     <= '0;
            r_key       <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_ticks <= '0;
                    if (w_press) begin
                        r_state     <= StPressWait;
                        r_last_edge <= EdgePress;
                    end
                end
                StPressWait: begin
                    if (w_press) begin
                        r_last_edge <= EdgePress;
                    end else if (w_release) begin
                        r_last_edge <= EdgeRelease;
                    end else if (w_done) begin
                        if (r_last_edge == EdgePress) begin
                            r_state <= StHeld;
                            r_ticks <= '0;
                            r_key   <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                StHeld: begin
                    if (w_release) begin
                        r_state     <= StReleaseWait;
                        r_last_edge <= EdgeRelease;
                    end else if (w_done && (r_ticks < LONG_TICKS)) begin
                        // Saturates at LONG_TICKS so the long pulse fires only once.
                        r_ticks <= r_ticks + TickW'(1);
                        if ((r_ticks + TickW'(1)) == LONG_TICKS) begin
                            r_long <= 1'b1;
                        end
                    end
                end
                StReleaseWait: begin
                    if (w_press) begin
                        r_last_edge <= EdgePress;
                    end else if (w_release) begin
                        r_last_edge <= EdgeRelease;
                    end else if (w_done) begin
                        if (r_last_edge == EdgeRelease) begin
                            r_state   <= StIdle;
                            r_key     <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_state <= StHeld;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign Key_Out       = r_key;
    assign Press_Pulse   = r_press;
    assign Release_Pulse = r_release;
    assign Long_Sig      = r_long;

endmodule

// File: tb/tb_debounce_delay_module.sv
// Directed bench for debounce_delay_module with a deadline-based reference model
// checked after every clock edge, plus literal timing checks per scenario.
module tb_debounce_delay_module;

    localparam int T  = 9;
    localparam int LT = 3;

    localparam int MIdle = 0;
    localparam int MPw   = 1;
    localparam int MHeld = 2;
    localparam int MRw   = 3;

    logic CLK;
    logic RST;
    logic H2L_Sig;
    logic L2H_Sig;
    logic Key_Out;
    logic Press_Pulse;
    logic Release_Pulse;
    logic Long_Sig;

    debounce_delay_module #(
        .T10MS      (19'd9),
        .LONG_TICKS (7'd3)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .H2L_Sig       (H2L_Sig),
        .L2H_Sig       (L2H_Sig),
        .Key_Out       (Key_Out),
        .Press_Pulse   (Press_Pulse),
        .Release_Pulse (Release_Pulse),
        .Long_Sig      (Long_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: phase plus absolute deadlines in clock-edge numbers.
    int   m_phase    = MIdle;
    bit   m_last_prs = 1'b0;
    int   m_deadline = 0;
    int   m_tick_due = 0;
    int   m_ticks    = 0;
    logic m_key      = 1'b0;
    logic e_press    = 1'b0;
    logic e_rel      = 1'b0;
    logic e_long     = 1'b0;

    int first_press, first_key, first_keylo, first_long, first_rel;
    int n_press, n_rel, n_long, n_keyhi, n_keylo;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        first_press = -1; first_key = -1; first_keylo = -1; first_long = -1; first_rel = -1;
        n_press = 0; n_rel = 0; n_long = 0; n_keyhi = 0; n_keylo = 0;
    endtask

    task automatic model_step(input logic h, input logic l, input logic rst, input int c);
        bit p;
        bit r;
        p = h & ~l;
        r = l & ~h;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        if (rst) begin
            m_phase = MIdle; m_last_prs = 1'b0; m_ticks = 0; m_key = 1'b0;
        end else begin
            case (m_phase)
                MIdle: if (p) begin
                    m_phase = MPw; m_last_prs = 1'b1; m_deadline = c + T + 1;
                end
                MPw: if (p || r) begin
                    m_last_prs = p; m_deadline = c + T + 1;
                end else if (c == m_deadline) begin
                    if (m_last_prs) begin
                        m_phase = MHeld; m_key = 1'b1; e_press = 1'b1;
                        m_ticks = 0; m_tick_due = c + T + 1;
                    end else begin
                        m_phase = MIdle;
                    end
                end
                MHeld: if (r) begin
                    m_phase = MRw; m_last_prs = 1'b0; m_deadline = c + T + 1;
                end else if (c == m_tick_due) begin
                    m_tick_due = m_tick_due + T + 1;
                    if (m_ticks < LT) begin
                        m_ticks++;
                        if (m_ticks == LT) e_long = 1'b1;
                    end
                end
                default: if (p || r) begin
                    m_last_prs = p; m_deadline = c + T + 1;
                end else if (c == m_deadline) begin
                    if (!m_last_prs) begin
                        m_phase = MIdle; m_key = 1'b0; e_rel = 1'b1;
                    end else begin
                        m_phase = MHeld; m_tick_due = c + T + 1;
                    end
                end
            endcase
        end
    endtask

    // One clock: drive, predict, clock, then compare away from the edge.
    task automatic step(input logic h, input logic l, input logic rst);
        H2L_Sig = h;
        L2H_Sig = l;
        RST     = rst;
        model_step(h, l, rst, cyc + 1);
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        check_vec("outputs", {Key_Out, Press_Pulse, Release_Pulse, Long_Sig},
                  {m_key, e_press, e_rel, e_long});
        check("pulse_exclusive", int'($countones({Press_Pulse, Release_Pulse, Long_Sig})) <= 1,
              1);
        if (Press_Pulse) begin n_press++; if (first_press < 0) first_press = cyc; end
        if (Release_Pulse) begin n_rel++; if (first_rel < 0) first_rel = cyc; end
        if (Long_Sig) begin n_long++; if (first_long < 0) first_long = cyc; end
        if (Key_Out) begin n_keyhi++; if (first_key < 0) first_key = cyc; end
        else begin n_keylo++; if (first_keylo < 0) first_keylo = cyc; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    int s;

    initial begin
        H2L_Sig = 1'b0;
        L2H_Sig = 1'b0;
        RST     = 1'b1;
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        check_vec("reset_outputs", {Key_Out, Press_Pulse, Release_Pulse, Long_Sig}, 4'b0000);
        idle(2);

        // Clean press, then hold long enough for the long-press pulse.
        clear_obs();
        s = cyc + 1;
        step(1'b1, 1'b0, 1'b0);
        idle(60);
        check("clean_press_cycle", first_press - s + 1, 11);
        check("clean_key_rise_cycle", first_key - s + 1, 11);
        check("press_count", n_press, 1);
        check("long_after_press", first_long - first_press, 30);
        check("long_count", n_long, 1);

        // Release from HELD.
        clear_obs();
        s = cyc + 1;
        step(1'b0, 1'b1, 1'b0);
        idle(15);
        check("release_cycle", first_rel - s + 1, 11);
        check("key_fall_cycle", first_keylo - s + 1, 11);
        check("release_count", n_rel, 1);

        // Bouncing press: H2L at 0 and 4, L2H at 2.
        clear_obs();
        s = cyc + 1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(20);
        check("bounce_press_cycle", first_press - s + 1, 15);

        // Release bounce that settles pressed: back to HELD, key never drops.
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 1'b0);
        idle(20);
        check("rw_bounce_release_count", n_rel, 0);
        check("rw_bounce_key_low", n_keylo, 0);
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        idle(15);
        check("rw_final_release_count", n_rel, 1);

        // Glitch: press then release before settling.
        clear_obs();
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b0);
        idle(25);
        check("glitch_press_count", n_press, 0);
        check("glitch_key_high", n_keyhi, 0);

        // Reset while PRESS_WAIT has counted to 5.
        clear_obs();
        step(1'b1, 1'b0, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 1'b1);
        check_vec("reset_mid_wait", {Key_Out, Press_Pulse, Release_Pulse, Long_Sig}, 4'b0000);
        idle(20);
        check("reset_abort_press_count", n_press, 0);

        // Simultaneous edges in IDLE, then a press arriving during reset.
        clear_obs();
        step(1'b1, 1'b1, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 1'b1);
        idle(20);
        check("ignored_edges_press_count", n_press, 0);
        check("ignored_edges_key_high", n_keyhi, 0);
        check_vec("final_outputs", {Key_Out, Press_Pulse, Release_Pulse, Long_Sig}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
